// File: rtl/instr_fetch.sv
// Instruction fetch stage: captures the PC, runs a handshaked read to instruction
// memory and buffers returned words in a 2-entry FIFO toward the decoder.
//
// state | meaning
// IDLE  | waiting for fetch_en and a free queue slot
// REQ   | read outstanding, word is pushed on ack
// STEP  | one settle cycle so the PC reflects the pc_inc pulse
// DRAIN | read outstanding after a flush, returned word is dropped
module instr_fetch #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic [WORD_SIZE-1:0] pc_in,
    output logic                 pc_inc,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 ir_valid,
    output logic [WORD_SIZE-1:0] ir_data,
    output logic [WORD_SIZE-1:0] ir_pc,
    input  logic                 ir_ready
);

    typedef enum logic [1:0] {IDLE, REQ, STEP, DRAIN} state_t;

    state_t               state_q;
    logic                 mem_req_q;
    logic [WORD_SIZE-1:0] mem_addr_q;
    logic                 pc_inc_q;

    logic [1:0]           count_q, count_d;
    logic [WORD_SIZE-1:0] head_data_q, head_data_d;
    logic [WORD_SIZE-1:0] head_pc_q, head_pc_d;
    logic [WORD_SIZE-1:0] tail_data_q, tail_data_d;
    logic [WORD_SIZE-1:0] tail_pc_q, tail_pc_d;

    logic push;
    logic pop;

    assign push = (state_q == REQ) && mem_ack && !flush;
    assign pop  = (count_q != 2'd0) && ir_ready;

    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        tail_data_d = tail_data_q;
        tail_pc_d   = tail_pc_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_d = mem_rdata;
                        head_pc_d   = mem_addr_q;
                    end else begin
                        tail_data_d = mem_rdata;
                        tail_pc_d   = mem_addr_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_pc_d   = tail_pc_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    // Count holds; the incoming word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_data_d = mem_rdata;
                        head_pc_d   = mem_addr_q;
                    end else begin
                        head_data_d = tail_data_q;
                        head_pc_d   = tail_pc_q;
                        tail_data_d = mem_rdata;
                        tail_pc_d   = mem_addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            pc_inc_q    <= 1'b0;
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_pc_q   <= '0;
            tail_data_q <= '0;
            tail_pc_q   <= '0;
        end else begin
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
            tail_data_q <= tail_data_d;
            tail_pc_q   <= tail_pc_d;
            pc_inc_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    // An outstanding read reserves its slot, so a push never finds the queue full.
                    if (fetch_en && !flush && (count_q < 2'd2)) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_in;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            pc_inc_q <= 1'b1;
                            state_q  <= STEP;
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                STEP: begin
                    state_q <= IDLE;
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign pc_inc   = pc_inc_q;
    assign ir_valid = (count_q != 2'd0);
    assign ir_data  = head_data_q;
    assign ir_pc    = head_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then randomized traffic, all checked
// every cycle against a queue-based transaction model.
module tb_instr_fetch;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_en;
    logic [W-1:0] pc_in;
    logic         pc_inc;
    logic         flush;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;
    logic         ir_valid;
    logic [W-1:0] ir_data;
    logic [W-1:0] ir_pc;
    logic         ir_ready;

    always #5 clk = ~clk;

    instr_fetch #(.WORD_SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .pc_in     (pc_in),
        .pc_inc    (pc_inc),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_valid  (ir_valid),
        .ir_data   (ir_data),
        .ir_pc     (ir_pc),
        .ir_ready  (ir_ready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding read, a cooldown count after a
    // successful fetch, and a plain queue of returned words.
    bit           e_req;
    bit           e_inc;
    bit           e_disc;
    int           e_cool;
    logic [W-1:0] e_addr;
    logic [W-1:0] qd[$];
    logic [W-1:0] qp[$];

    logic [W-1:0] flush_tgt;
    bit           auto_mem;
    bit           busy;
    bit           acked;
    int           lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit           do_push;
        logic [W-1:0] nd;
        logic [W-1:0] np;
        int           cnt;
        do_push = 1'b0;
        nd      = '0;
        np      = '0;
        cnt     = qd.size();
        if (rst) begin
            e_req  = 1'b0;
            e_inc  = 1'b0;
            e_disc = 1'b0;
            e_cool = 0;
            e_addr = '0;
            qd.delete();
            qp.delete();
        end else begin
            e_inc = 1'b0;
            if (e_req) begin
                if (mem_ack) begin
                    e_req = 1'b0;
                    if (!e_disc && !flush) begin
                        do_push = 1'b1;
                        nd      = mem_rdata;
                        np      = e_addr;
                        e_inc   = 1'b1;
                        e_cool  = 1;
                    end else begin
                        e_cool = 0;
                    end
                    e_disc = 1'b0;
                end else if (flush) begin
                    e_disc = 1'b1;
                end
            end else if (e_cool > 0) begin
                e_cool--;
            end else if (fetch_en && !flush && cnt < 2) begin
                e_req  = 1'b1;
                e_addr = pc_in;
            end
            if (flush) begin
                qd.delete();
                qp.delete();
            end else begin
                if (cnt > 0 && ir_ready) begin
                    void'(qd.pop_front());
                    void'(qp.pop_front());
                end
                if (do_push) begin
                    qd.push_back(nd);
                    qp.push_back(np);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_req", mem_req, e_req);
        if (e_req) chk("mem_addr", mem_addr, e_addr);
        chk("pc_inc", pc_inc, e_inc);
        chk("ir_valid", ir_valid, qd.size() > 0);
        if (qd.size() > 0) begin
            chk("ir_data", ir_data, qd[0]);
            chk("ir_pc", ir_pc, qp[0]);
        end
    endtask

    // One clock: model and DUT advance on the edge, outputs compared on the
    // falling edge, then the bench PC and memory respond.
    task automatic tick();
        bit inc_s;
        inc_s = (pc_inc === 1'b1);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (flush) pc_in = flush_tgt;
        else if (inc_s) pc_in = pc_in + 1'b1;
        flush = 1'b0;
        if (mem_ack) begin
            mem_ack = 1'b0;
            acked   = 1'b1;
        end
        if (!mem_req) begin
            busy  = 1'b0;
            acked = 1'b0;
        end else if (auto_mem && !acked) begin
            if (!busy) begin
                busy = 1'b1;
                lat  = $urandom_range(0, 3);
            end
            if (lat == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = W'($urandom);
            end else begin
                lat--;
            end
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst pc_inc", pc_inc, 0);
        chk("rst ir_valid", ir_valid, 0);
        chk("rst ir_data", ir_data, 0);
        chk("rst ir_pc", ir_pc, 0);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
        pc_in = '0; mem_rdata = '0; flush_tgt = '0;
        auto_mem = 1'b0; busy = 1'b0; acked = 1'b0; lat = 0;
        e_req = 1'b0; e_inc = 1'b0; e_disc = 1'b0; e_cool = 0; e_addr = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk_reset_vals();

        // basic fetch, zero-wait memory
        fetch_en = 1'b1;
        tick();
        chk("t1 req", mem_req, 1); chk("t1 addr", mem_addr, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        chk("t1 valid", ir_valid, 1); chk("t1 data", ir_data, 16'h1234);
        chk("t1 pc", ir_pc, 16'h0000); chk("t1 inc", pc_inc, 1); chk("t1 req low", mem_req, 0);
        tick();
        chk("t1 inc off", pc_inc, 0); chk("t1 no req", mem_req, 0);
        tick();
        chk("t1 next req", mem_req, 1); chk("t1 next addr", mem_addr, 16'h0001);

        // queue fills to two, then a single pop frees a slot
        mem_ack = 1'b1; mem_rdata = 16'h5678;
        tick(); tick();
        repeat (4) tick();
        chk("t2 stall req", mem_req, 0); chk("t2 head", ir_data, 16'h1234); chk("t2 valid", ir_valid, 1);
        ir_ready = 1'b1;
        tick();
        chk("t2 pop data", ir_data, 16'h5678); chk("t2 pop pc", ir_pc, 16'h0001);
        ir_ready = 1'b0;
        tick();
        chk("t2 reissue", mem_req, 1); chk("t2 reissue addr", mem_addr, 16'h0002);

        // flush while the read is outstanding
        flush = 1'b1; flush_tgt = 16'h0040;
        tick();
        chk("t3 flushed", ir_valid, 0); chk("t3 req held", mem_req, 1);
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        chk("t3 drain req", mem_req, 0); chk("t3 drain inc", pc_inc, 0); chk("t3 drain valid", ir_valid, 0);
        tick();
        chk("t3 new req", mem_req, 1); chk("t3 new addr", mem_addr, 16'h0040);

        // flush coincident with ack
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; flush = 1'b1; flush_tgt = 16'h0080;
        tick();
        chk("t4 valid", ir_valid, 0); chk("t4 inc", pc_inc, 0); chk("t4 req", mem_req, 0);
        tick();
        chk("t4 new addr", mem_addr, 16'h0080);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        chk("t4 data", ir_data, 16'h1111); chk("t4 pc", ir_pc, 16'h0080);

        // simultaneous push and pop with one entry held
        tick(); tick();
        chk("t5 addr", mem_addr, 16'h0081);
        mem_ack = 1'b1; mem_rdata = 16'h2222; ir_ready = 1'b1;
        tick();
        chk("t5 valid", ir_valid, 1); chk("t5 data", ir_data, 16'h2222); chk("t5 pc", ir_pc, 16'h0081);
        ir_ready = 1'b0;

        // reset mid-request, late ack ignored
        tick(); tick();
        chk("t6 req", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals();
        mem_ack = 1'b1; mem_rdata = 16'h3333; fetch_en = 1'b0;
        tick();
        chk("t6 late valid", ir_valid, 0); chk("t6 late req", mem_req, 0);

        // randomized traffic
        auto_mem = 1'b1;
        repeat (3000) begin
            fetch_en  = ($urandom_range(0, 3) != 0);
            ir_ready  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            flush_tgt = W'($urandom);
            rst       = ($urandom_range(0, 249) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the program counter. It reads the current PC value, issues a handshaked read to instruction memory, buffers returned words in a 2-entry queue for the decoder, and pulses the PC increment control (offset=1, data_in=1) once per accepted fetch. A one-cycle flush from branch resolution discards queued and in-flight instructions so fetch restarts from the newly loaded PC.

## Interface
- WORD_SIZE, 16, width of PC, address and instruction words
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- fetch_en  input  1  permits new memory requests when high
- pc_in  input  WORD_SIZE  current PC value (pc_counter)
- pc_inc  output  1  one-cycle pulse; drives PC offset input with data_in=1
- flush  input  1  one-cycle redirect; coincides with load_pc at the PC
- mem_req  output  1  read request to instruction memory
- mem_addr  output  WORD_SIZE  read address, stable while mem_req high
- mem_ack  input  1  one-cycle pulse; mem_rdata valid in that cycle
- mem_rdata  input  WORD_SIZE  returned instruction word
- ir_valid  output  1  queue head valid toward decoder
- ir_data  output  WORD_SIZE  queue head instruction
- ir_pc  output  WORD_SIZE  address the head instruction was fetched from
- ir_ready  input  1  decoder accepts head when ir_valid && ir_ready

## Operation
- States: IDLE, REQ, STEP, DRAIN.
- IDLE: if fetch_en && !flush && (count + 0) < 2 -> REQ; register mem_addr <= pc_in, mem_req <= 1.
- REQ: hold mem_req, mem_addr. On mem_ack && !flush: push {mem_rdata, mem_addr} into queue, mem_req <= 0, pc_inc <= 1, -> STEP. On flush without ack -> DRAIN (mem_req stays high). On flush with ack: data discarded, no pc_inc, -> IDLE.
- STEP: pc_inc <= 0; -> IDLE (lets PC settle before next address capture).
- DRAIN: hold mem_req until mem_ack; discard mem_rdata, no push, no pc_inc; -> IDLE with mem_req <= 0.
- Queue: 2 entries, FIFO order, count 0..2. Push only from REQ ack; pop on ir_valid && ir_ready. Request issued only if count < 2 at issue time (outstanding request reserves a slot, so a push never meets a full queue).
- Simultaneous push and pop: count unchanged, order preserved.
- Flush: count <= 0, ir_valid <= 0 at next edge, regardless of ir_ready or ack in that cycle; pc_inc forced 0 in flush cycle's next edge. flush in IDLE/STEP -> IDLE.
- fetch_en low: no new request; an outstanding request completes normally.
- No arithmetic on PC inside the block; PC advance is solely via pc_inc.

## Timing
- Reset (synchronous): state IDLE, count 0, mem_req 0, mem_addr 0, pc_inc 0, ir_valid 0, ir_data 0, ir_pc 0.
- Request issue: mem_req high 1 cycle after IDLE condition is met.
- Ack in cycle N: queue entry visible (ir_valid=1 if queue was empty) in N+1; pc_inc high in N+1 only; earliest next mem_req in N+3 with new pc_in.
- Zero-wait memory (ack 1 cycle after req rises): sustained throughput 1 instruction per 4 cycles.
- ir_data/ir_pc/ir_valid registered; no combinational path from mem_ack or ir_ready to outputs.
- rst mid-request: mem_req drops next edge; any later mem_ack ignored (state IDLE).

## Test plan
- Reset then fetch_en=1, pc_in=0x0000, memory acks 1 cycle after req with 0x1234 -> mem_addr=0x0000, ir_valid=1, ir_data=0x1234, ir_pc=0x0000, single pc_inc pulse.
- ir_ready=0, three fetch opportunities -> exactly 2 entries queued, mem_req stays 0 after second ack; ir_ready=1 for one cycle -> third request issued.
- flush while in REQ, ack arrives 3 cycles later with 0xDEAD -> mem_req held until ack, no push, no pc_inc, ir_valid=0; next fetch uses new pc_in=0x0040.
- flush in the same cycle as mem_ack -> data discarded, queue empty, no pc_inc.
- Queue holds 1 entry, pop and push same cycle -> count stays 1, ir_data advances to the newer word in FIFO order.
- rst asserted with mem_req high -> all outputs at reset values next cycle, late ack produces no entry.
